booth_r4_seq_mult: RTL and testbench



---
 rtl/booth_pkg.sv | 35 +++
 rtl/booth_r4_pp_sel.sv | 39 +++
 rtl/booth_r4_seq_mult.sv | 125 ++++++++++++
 tb/tb_booth_r4_seq_mult.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier:
// FSM states, Booth digit encoding and the window decoder.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } booth_state_t;

  typedef enum logic [2:0] {
    DIG_ZERO,
    DIG_POS1,
    DIG_POS2,
    DIG_NEG2,
    DIG_NEG1
  } booth_dig_t;

  function automatic booth_dig_t booth_decode(
    input logic [2:0] win
  );
    booth_dig_t d;
    d = DIG_ZERO;
    unique case (win)
      3'b000, 3'b111: d = DIG_ZERO;
      3'b001, 3'b010: d = DIG_POS1;
      3'b011:         d = DIG_POS2;
      3'b100:         d = DIG_NEG2;
      3'b101, 3'b110: d = DIG_NEG1;
      default:        d = DIG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_pp_sel.sv
// Booth partial-product selector: scales the extended
// multiplicand by one digit and aligns it to digit idx.
module booth_r4_pp_sel
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SW    = 4
) (
  input  logic [WIDTH+1:0]   a_ext,
  input  logic [2:0]         win,
  input  logic [SW-1:0]      idx,
  output logic [2*WIDTH-1:0] pp
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] a_w;
  logic [PW-1:0] mag;
  logic [SW:0]   sh;
  booth_dig_t    dig;

  assign a_w = {{(PW-WIDTH-2){a_ext[WIDTH+1]}}, a_ext};
  assign sh  = {idx, 1'b0};

  // Scale by the decoded digit, then shift into place.
  always_comb begin
    dig = booth_decode(win);
    mag = '0;
    unique case (dig)
      DIG_POS1: mag = a_w;
      DIG_POS2: mag = a_w << 1;
      DIG_NEG2: mag = -(a_w << 1);
      DIG_NEG1: mag = -a_w;
      default:  mag = '0;
    endcase
    pp = mag << sh;
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one digit per clock,
// valid/ready on operands and result, signed/unsigned mode.
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               alu_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               neg_flag,
  output logic               zero_flag,
  output logic               busy
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int SW   = $clog2(NDIG);
  localparam int PW   = 2 * WIDTH;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
  end

  booth_state_t state;
  booth_state_t state_nxt;

  logic [WIDTH+1:0] a_r;
  logic [WIDTH+2:0] b_r;
  logic             sgn_r;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_nxt;
  logic [PW-1:0]    pp;
  logic [SW-1:0]    cnt;
  logic             last;
  logic             accept;
  logic             ext_a;
  logic             ext_b;

  assign last   = (cnt == SW'(NDIG - 1));
  assign accept = (state == IDLE) && in_valid;
  assign ext_a  = alu_signed & a[WIDTH-1];
  assign ext_b  = alu_signed & b[WIDTH-1];

  // b_r shifts right two bits per digit, so the
  // current window always sits in its low three bits.
  booth_r4_pp_sel #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_pp_sel (
    .a_ext (a_r),
    .win   (b_r[2:0]),
    .idx   (cnt),
    .pp    (pp)
  );

  assign acc_nxt = acc + pp;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit accumulation, result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      sgn_r     <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      product   <= '0;
      neg_flag  <= 1'b0;
      zero_flag <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      a_r   <= {ext_a, ext_a, a};
      b_r   <= {ext_b, ext_b, b, 1'b0};
      sgn_r <= alu_signed;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      b_r <= b_r >> 2;
      cnt <= cnt + SW'(1);
      if (last) begin
        product   <= acc_nxt;
        zero_flag <= (acc_nxt == '0);
        neg_flag  <= sgn_r & acc_nxt[PW-1];
        out_valid <= 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Scoreboard bench for booth_r4_seq_mult (WIDTH=16):
// directed corners, backpressure, reset abort, random sweep.
module tb_booth_r4_seq_mult;

  localparam int W = 16;

  typedef struct packed {
    logic [31:0] p;
    logic        n;
    logic        z;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          alu_signed = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] product;
  logic          neg_flag;
  logic          zero_flag;
  logic          busy;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  logic [15:0] extremes [5] = '{16'h0000, 16'h0001,
                                16'h7FFF, 16'h8000, 16'hFFFF};

  booth_r4_seq_mult #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alu_signed (alu_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .neg_flag   (neg_flag),
    .zero_flag  (zero_flag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [15:0] x, logic [15:0] y,
                                 logic s);
    longint px, py, pr;
    exp_t e;
    px = s ? longint'($signed(x)) : longint'(x);
    py = s ? longint'($signed(y)) : longint'(y);
    pr = px * py;
    e.p = pr[31:0];
    e.n = s & e.p[31];
    e.z = (e.p == 32'd0);
    return e;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    e = '1;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  // Drives one operand request; the accept edge is the next posedge.
  task automatic issue(input logic [15:0] x, input logic [15:0] y,
                       input logic s, input exp_t e, input bit push);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
    end
    a = x; b = y; alu_signed = s; in_valid = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks += 6;
    if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0) begin n_fail++;
      $display("FAIL rst_busy: got %b want 0", busy); end
    if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (product !== 32'd0) begin n_fail++;
      $display("FAIL rst_product: got %h want 0", product); end
    if (neg_flag !== 1'b0) begin n_fail++;
      $display("FAIL rst_neg: got %b want 0", neg_flag); end
    if (zero_flag !== 1'b0) begin n_fail++;
      $display("FAIL rst_zero: got %b want 0", zero_flag); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks += 2;
    if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0) begin n_fail++;
      $display("FAIL post_rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [15:0] ta [6] = '{16'hFFFF, 16'hFFFF, 16'h8000,
                            16'h8000, 16'h1234, 16'h1234};
    logic [15:0] tb [6] = '{16'hFFFF, 16'hFFFF, 16'h8000,
                            16'h0001, 16'h0000, 16'h0000};
    logic        ts [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] tp [6] = '{32'h00000001, 32'hFFFE0001,
                            32'h40000000, 32'hFFFF8000,
                            32'h0, 32'h0};
    logic        tn [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        tz [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      exp_t g;
      int lat;
      e.p = tp[i]; e.n = tn[i]; e.z = tz[i];
      issue(ta[i], tb[i], ts[i], e, 1'b1);
      wait_valid(lat);
      g = pop_exp();
      n_checks += 4;
      if (lat != 9) begin n_fail++;
        $display("FAIL dir%0d_latency: got %0d want 9", i, lat); end
      if (product !== g.p) begin n_fail++;
        $display("FAIL dir%0d_product: got %h want %h", i, product, g.p); end
      if (neg_flag !== g.n) begin n_fail++;
        $display("FAIL dir%0d_neg: got %b want %b", i, neg_flag, g.n); end
      if (zero_flag !== g.z) begin n_fail++;
        $display("FAIL dir%0d_zero: got %b want %b", i, zero_flag, g.z); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    exp_t g;
    int lat;
    out_ready = 1'b0;
    e = model(16'hABCD, 16'h1357, 1'b1);
    issue(16'hABCD, 16'h1357, 1'b1, e, 1'b1);
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222; alu_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks += 2;
    if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL bp_run_in_ready: got %b want 0", in_ready); end
    if (busy !== 1'b1) begin n_fail++;
      $display("FAIL bp_run_busy: got %b want 1", busy); end
    wait_valid(lat);
    g = pop_exp();
    in_valid = 1'b1; a = 16'h0003; b = 16'h0003;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks += 5;
      if (out_valid !== 1'b1) begin n_fail++;
        $display("FAIL bp%0d_out_valid: got %b want 1", k, out_valid); end
      if (product !== g.p) begin n_fail++;
        $display("FAIL bp%0d_product: got %h want %h", k, product, g.p); end
      if (neg_flag !== g.n) begin n_fail++;
        $display("FAIL bp%0d_neg: got %b want %b", k, neg_flag, g.n); end
      if (zero_flag !== g.z) begin n_fail++;
        $display("FAIL bp%0d_zero: got %b want %b", k, zero_flag, g.z); end
      if (in_ready !== 1'b0) begin n_fail++;
        $display("FAIL bp%0d_in_ready: got %b want 0", k, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks += 3;
    if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL bp_drop_valid: got %b want 0", out_valid); end
    if (busy !== 1'b0) begin n_fail++;
      $display("FAIL bp_idle_busy: got %b want 0", busy); end
    if (product !== g.p) begin n_fail++;
      $display("FAIL bp_hold_product: got %h want %h", product, g.p); end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++;
      $display("FAIL bp_no_queue: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    exp_t g;
    int lat;
    e = '0;
    issue(16'hFFFF, 16'hFFFF, 1'b0, e, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks += 6;
    if (product !== 32'd0) begin n_fail++;
      $display("FAIL abort_product: got %h want 0", product); end
    if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL abort_out_valid: got %b want 0", out_valid); end
    if (neg_flag !== 1'b0) begin n_fail++;
      $display("FAIL abort_neg: got %b want 0", neg_flag); end
    if (zero_flag !== 1'b0) begin n_fail++;
      $display("FAIL abort_zero: got %b want 0", zero_flag); end
    if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0) begin n_fail++;
      $display("FAIL abort_busy: got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    e.p = 32'h0000000F; e.n = 1'b0; e.z = 1'b0;
    issue(16'd3, 16'd5, 1'b0, e, 1'b1);
    wait_valid(lat);
    g = pop_exp();
    n_checks += 3;
    if (lat != 9) begin n_fail++;
      $display("FAIL abort_next_latency: got %0d want 9", lat); end
    if (product !== g.p) begin n_fail++;
      $display("FAIL abort_next_product: got %h want %h", product, g.p); end
    if (neg_flag !== g.n) begin n_fail++;
      $display("FAIL abort_next_neg: got %b want %b", neg_flag, g.n); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int n_pairs;
    n_pairs = 25 + 1800;
    for (int i = 0; i < n_pairs; i++) begin
      logic [15:0] x, y;
      if (i < 25) begin
        x = extremes[i / 5];
        y = extremes[i % 5];
      end else begin
        x = ($urandom_range(0, 9) < 2) ?
            extremes[$urandom_range(0, 4)] : 16'($urandom);
        y = ($urandom_range(0, 9) < 2) ?
            extremes[$urandom_range(0, 4)] : 16'($urandom);
      end
      for (int m = 0; m < 2; m++) begin
        exp_t e;
        exp_t g;
        int lat;
        e = model(x, y, m[0]);
        issue(x, y, m[0], e, 1'b1);
        wait_valid(lat);
        g = pop_exp();
        n_checks += 3;
        if (product !== g.p) begin n_fail++;
          $display("FAIL rnd_product %h*%h s=%0d: got %h want %h",
                   x, y, m, product, g.p); end
        if (neg_flag !== g.n) begin n_fail++;
          $display("FAIL rnd_neg %h*%h s=%0d: got %b want %b",
                   x, y, m, neg_flag, g.n); end
        if (zero_flag !== g.z) begin n_fail++;
          $display("FAIL rnd_zero %h*%h s=%0d: got %b want %b",
                   x, y, m, zero_flag, g.z); end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    n_checks++;
    if (sb.size() != 0) begin n_fail++;
      $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
